fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences instruction fetch from the 256-word combinational ins_mem: owns the PC and drives the word address.
//  Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
//  Handles branch/jump redirects, halt requests and out-of-range faults.
//  Sits between ins_mem and the decode stage; also drives ins_mem's init strobe during boot.
// PARAMETERS
//  RESET_PC    32'h0000_0000  byte PC loaded on reset; must be word aligned
//  IMEM_DEPTH  256            ins_mem depth in words; word index >= IMEM_DEPTH is a fault
//  FIFO_DEPTH  2              fetch buffer entries; power of 2, >= 2
// PORTS
//  clk             in   1   single clock, rising edge
//  rst             in   1   synchronous, active-low reset (rst==0 sampled at posedge resets block)
//  imem_addr       out  32  word index to ins_mem = {2'b00, pc[31:2]}
//  imem_init       out  1   to ins_mem rst; high while rst==0 or state==BOOT
//  imem_data       in   32  ins_mem ins_out; combinational, valid same cycle as imem_addr
//  redirect_valid  in   1   one-cycle pulse: flush buffer and load redirect_pc
//  redirect_pc     in   32  byte target PC
//  halt_req        in   1   stop fetching (level or pulse, sampled each cycle)
//  inst_valid      out  1   head of FIFO holds an instruction
//  inst_ready      in   1   decode accepts head this cycle
//  inst_out        out  32  instruction word at head
//  inst_pc         out  32  byte PC of inst_out
//  halted          out  1   state==HALT and FIFO empty
//  fault           out  1   sticky: misaligned redirect or PC beyond IMEM_DEPTH
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=BOOT, FIFO empty; inst_valid=0, halted=0, fault=0; imem_init=1.
//  States: BOOT, FETCH, HALT, FAULT (2-bit encoding).
//   BOOT -> FETCH after exactly one cycle; no fetch issued in BOOT.
//   FETCH: fire = !full_eff && !redirect_valid && !halt_req && (pc>>2) < IMEM_DEPTH.
//   On fire: push {pc, imem_data}; pc += 4.
//   full_eff = full && !(inst_valid && inst_ready). Simultaneous push/pop on a full FIFO is allowed.
//   (pc>>2) >= IMEM_DEPTH in FETCH: no push; -> FAULT next edge.
//   halt_req in FETCH: no push; -> HALT. FIFO keeps draining.
//   HALT: no fetch. redirect_valid -> FETCH with the new pc. halt_req is ignored.
//   FAULT: terminal until reset. No fetch. redirect_valid and halt_req are ignored. FIFO keeps draining.
//  Redirect (in BOOT/FETCH/HALT):
//   - At the edge: FIFO cleared, pc <= redirect_pc, no push that cycle.
//   - A pop in the same cycle still counts as consumed by decode.
//   - redirect_pc[1:0] != 0 -> FAULT, fault=1.
//   - Redirect + halt_req in the same cycle: pc loaded, FIFO flushed, state -> HALT.
//   - Redirect in BOOT: pc loaded, state -> FETCH as normal.
//  Latency: first inst_valid rises 2 edges after rst first sampled high (BOOT edge, then push edge).
//   Thereafter 1 instruction/cycle when inst_ready is held high; redirect-to-valid is 2 edges.
//  Handshake: inst_out/inst_pc are held stable while inst_valid && !inst_ready.
//   inst_valid never drops without a pop, except on flush.
//  pc arithmetic is 32-bit unsigned; wrap at 2^32 is unreachable (range fault triggers first).
//  Reset asserted mid-operation: all state is discarded at that edge, with no further push or pop.
// STRUCTURE
//  fetch_defs.vh: state localparams (ST_BOOT/ST_FETCH/ST_HALT/ST_FAULT); INSN_W=32; PC_W=32.
//  Sub-module fetch_fifo: sync FIFO, 64-bit entries {pc,insn}, push/pop/flush, full/empty.
//   Flush has priority over push.
//  fetch_ctrl holds pc, the FSM and the fire/fault logic; the ins_mem instance lives in the parent.
// TESTING
//  1 Reset, then rst=1, ready=1 -> valid on edge 2; pc 0,4,8 with mem[0..2] on consecutive cycles.
//  2 ready=0 for 5 cycles -> FIFO fills to 2 entries; head stays pc=0, imem_addr holds 2.
//    Release -> pcs 0,4,8 in order, no gap.
//  3 redirect_pc=0x40 while FIFO full, ready=1 -> flushed; next valid inst_pc=0x40, inst_out=mem[16].
//  4 redirect_pc=0x3FC -> mem[255] delivered, then fault=1, state FAULT, no further valid;
//    a later redirect is ignored.
//  5 redirect_pc=0x42 -> fault=1 next edge, FIFO empty, inst_valid=0.
//  6 halt_req with 2 buffered -> both drained, then halted=1.
//    redirect 0x8 -> halted=0, next inst_pc=0x8. Mid-run rst=0 -> outputs return to reset values.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and widths for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned PC_W   = 32;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_index(input logic [PC_W-1:0] byte_pc);
    return {2'b00, byte_pc[PC_W-1:2]};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-to-decode valid/ready handshake carrying an instruction and its PC.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic              inst_valid;
  logic              inst_ready;
  logic [INSN_W-1:0] inst_out;
  logic [PC_W-1:0]   inst_pc;

  modport master (output inst_valid, inst_out, inst_pc, input inst_ready);
  modport slave  (input inst_valid, inst_out, inst_pc, output inst_ready);

endinterface

// File: rtl/fetch_ctrl_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, insn} entries; flush beats push.
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A push into a full buffer is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives ins_mem and feeds decode through a small buffer.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_DEPTH = 256,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_init,
  input  logic [INSN_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_req,
  fetch_ctrl_if.master      dec,
  output logic              halted,
  output logic              fault
);

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nxt;
  logic            push;
  logic            pop;
  logic            flush;
  logic            full;
  logic            empty;
  logic            full_eff;
  logic            in_range;
  fetch_entry_t    head;
  fetch_entry_t    entry;

  assign imem_addr = word_index(pc);
  assign imem_init = !rst || (state == ST_BOOT);
  assign in_range  = word_index(pc) < PC_W'(IMEM_DEPTH);
  assign pop       = dec.inst_valid && dec.inst_ready;
  assign full_eff  = full && !pop;
  assign entry     = '{pc: pc, insn: imem_data};

  assign dec.inst_valid = !empty;
  assign dec.inst_out   = head.insn;
  assign dec.inst_pc    = head.pc;
  assign halted         = (state == ST_HALT) && empty;
  assign fault          = (state == ST_FAULT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    flush     = 1'b0;

    unique case (state)
      ST_BOOT:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (!in_range)     state_nxt = ST_FAULT;
        else if (halt_req) state_nxt = ST_HALT;
        else if (!full_eff) begin
          push   = 1'b1;
          pc_nxt = pc + PC_W'(4);
        end
      end
      ST_HALT:  state_nxt = ST_HALT;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_FAULT;
    endcase

    // A redirect overrides whatever the state-specific logic chose this cycle.
    if (redirect_valid && state != ST_FAULT) begin
      flush  = 1'b1;
      push   = 1'b0;
      pc_nxt = redirect_pc;
      if (redirect_pc[1:0] != 2'b00)            state_nxt = ST_FAULT;
      else if (halt_req && state != ST_HALT)    state_nxt = ST_HALT;
      else                                      state_nxt = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: stream-level reference model feeding an expected-PC queue, checked by a monitor.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam logic [31:0] RESET_PC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_init;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        fault;
  logic [31:0] mem [IMEM_DEPTH];

  fetch_ctrl_if dec_if ();

  fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .IMEM_DEPTH(IMEM_DEPTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_init     (imem_init),
    .imem_data     (imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .dec           (dec_if),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  always_comb imem_data = (imem_addr < 32'(IMEM_DEPTH)) ? mem[imem_addr[7:0]] : 32'hDEAD_BEEF;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expq [$];
  bit          model_fault = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Program-order model: after a (re)start at target, decode must see target, target+4, ... to the end of memory.
  task automatic model_load(input logic [31:0] target);
    expq.delete();
    if (target[1:0] != 2'b00) model_fault = 1'b1;
    else for (int unsigned w = 32'(target >> 2); w < IMEM_DEPTH; w++) expq.push_back(32'(w) << 2);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      model_fault = 1'b0;
      model_load(RESET_PC);
    end else if (redirect_valid && !model_fault) begin
      model_load(redirect_pc);
    end
    #1;
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b0;
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    dec_if.inst_ready = ready;
    step();
    step();
    rst = 1'b1;
  endtask

  // Monitor: pops the expected queue on every accepted handshake and checks hold/fault rules.
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        predir = 1'b0;
  logic [31:0] pout = '0;
  logic [31:0] ppc = '0;
  logic [31:0] e;

  always @(negedge clk) begin
    if (rst) begin
      if (model_fault) check("fault_sticky", 32'(fault), 32'd1);
      else if (expq.size() > FIFO_DEPTH) check("fault_clear", 32'(fault), 32'd0);
      if (pv && !pr && !predir) begin
        check("hold_valid", 32'(dec_if.inst_valid), 32'd1);
        check("hold_pc", dec_if.inst_pc, ppc);
        check("hold_insn", dec_if.inst_out, pout);
      end
      if (dec_if.inst_valid && dec_if.inst_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc %h, expected no instruction", dec_if.inst_pc);
        end else begin
          e = expq.pop_front();
          check("pop_pc", dec_if.inst_pc, e);
          check("pop_insn", dec_if.inst_out, mem[e[9:2]]);
        end
      end
      pv     = dec_if.inst_valid;
      pr     = dec_if.inst_ready;
      predir = redirect_valid;
      pout   = dec_if.inst_out;
      ppc    = dec_if.inst_pc;
    end else begin
      pv = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  int halt_cnt;

  initial begin
    for (int i = 0; i < int'(IMEM_DEPTH); i++) mem[i] = $urandom;
    dec_if.inst_ready = 1'b1;

    // 1: reset values, two-edge start-up latency, back-to-back delivery
    do_reset(1'b1);
    check("rst_valid", 32'(dec_if.inst_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_init", 32'(imem_init), 32'd1);
    check("rst_addr", imem_addr, 32'd0);
    step();
    check("boot_valid", 32'(dec_if.inst_valid), 32'd0);
    check("boot_init", 32'(imem_init), 32'd0);
    step();
    check("first_valid", 32'(dec_if.inst_valid), 32'd1);
    check("first_addr", imem_addr, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stream_valid", 32'(dec_if.inst_valid), 32'd1);
    end

    // 2: backpressure fills the buffer, then releases with no gap
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) step();
    check("bp_valid", 32'(dec_if.inst_valid), 32'd1);
    check("bp_head_pc", dec_if.inst_pc, 32'd0);
    check("bp_addr", imem_addr, 32'd2);
    dec_if.inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_nogap", 32'(dec_if.inst_valid), 32'd1);
    end

    // 3: redirect on a full buffer
    dec_if.inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    dec_if.inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("redir_flush", 32'(dec_if.inst_valid), 32'd0);
    step();
    check("redir_valid", 32'(dec_if.inst_valid), 32'd1);
    check("redir_pc", dec_if.inst_pc, 32'h40);
    check("redir_insn", dec_if.inst_out, mem[16]);

    // 4: last word, then range fault; later redirects ignored
    redirect_valid = 1'b1;
    redirect_pc = 32'h3FC;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    model_fault = 1'b1;
    check("range_fault", 32'(fault), 32'd1);
    check("range_valid", 32'(dec_if.inst_valid), 32'd0);
    check("range_empty_q", 32'(expq.size()), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("fault_ign_valid", 32'(dec_if.inst_valid), 32'd0);
    check("fault_ign_fault", 32'(fault), 32'd1);

    // 5: misaligned redirect
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    check("misal_fault", 32'(fault), 32'd1);
    check("misal_valid", 32'(dec_if.inst_valid), 32'd0);

    // 6: halt drains the buffer, redirect resumes, mid-run reset
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    check("halt_pre_pc", dec_if.inst_pc, 32'd0);
    halt_req = 1'b1;
    dec_if.inst_ready = 1'b1;
    for (int i = 0; i < 8 && !halted; i++) step();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_valid", 32'(dec_if.inst_valid), 32'd0);
    check("halt_drained", 32'(expq.size()), 32'(IMEM_DEPTH - 2));
    halt_req = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    step();
    redirect_valid = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    step();
    check("resume_valid", 32'(dec_if.inst_valid), 32'd1);
    check("resume_pc", dec_if.inst_pc, 32'h8);
    step();
    step();
    rst = 1'b0;
    step();
    check("midrst_valid", 32'(dec_if.inst_valid), 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    check("midrst_fault", 32'(fault), 32'd0);
    check("midrst_init", 32'(imem_init), 32'd1);
    check("midrst_addr", imem_addr, 32'd0);

    // Randomized traffic: backpressure, halt bursts, aligned redirects
    do_reset(1'b1);
    halt_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      dec_if.inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = 1'b0;
      if (halt_cnt > 0) begin
        halt_req = 1'b1;
        halt_cnt--;
      end else if ($urandom_range(0, 49) == 0) begin
        halt_req = 1'b1;
        halt_cnt = $urandom_range(0, 2);
      end else begin
        halt_req = 1'b0;
      end
      if (!model_fault && expq.size() > FIFO_DEPTH && $urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'($urandom_range(0, 180)) << 2;
      end
      step();
    end
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
